// File: rtl/key_filter_multi.sv
// key_filter_multi: N-channel key debouncer with press/release flags, long-press and auto-repeat pulses
module key_filter_multi #(
  parameter int KEY_NUM      = 4,
  parameter int ACTIVE_LEVEL = 0,
  parameter int FILTER_CYC   = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_rpt
);
  localparam int DW = FILTER_CYC > 1 ? $clog2(FILTER_CYC) : 1;
  localparam int HW = LONG_CYC > 1 ? $clog2(LONG_CYC) : 1;
  localparam int RW = REPEAT_CYC > 1 ? $clog2(REPEAT_CYC) : 1;
  localparam logic ACT = ACTIVE_LEVEL != 0;
  localparam logic [DW-1:0] DMAX = DW'(FILTER_CYC - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYC - 1);
  typedef enum logic [1:0] {IDLE, FILTER0, DOWN, FILTER1} state_t;
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic [1:0] sync;
    logic act, rep, rep_n, flag, flag_n, state, state_n, lng, lng_n, rpt, rpt_n;
    state_t st, st_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [RW-1:0] rcnt, rcnt_n;
    assign act = sync[1] == ACT;
    always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
        sync  <= {2{~ACT}};
        st    <= IDLE;
        dcnt  <= '0;
        hcnt  <= '0;
        rcnt  <= '0;
        rep   <= 1'b0;
        flag  <= 1'b0;
        state <= 1'b1;
        lng   <= 1'b0;
        rpt   <= 1'b0;
      end else begin
        sync  <= {sync[0], key_in[i]};
        st    <= st_n;
        dcnt  <= dcnt_n;
        hcnt  <= hcnt_n;
        rcnt  <= rcnt_n;
        rep   <= rep_n;
        flag  <= flag_n;
        state <= state_n;
        lng   <= lng_n;
        rpt   <= rpt_n;
      end
    always_comb begin
      st_n    = st;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      rcnt_n  = rcnt;
      rep_n   = rep;
      flag_n  = 1'b0;
      state_n = state;
      lng_n   = 1'b0;
      rpt_n   = 1'b0;
      case (st)
        IDLE:
          if (act) begin
            st_n   = FILTER0;
            dcnt_n = '0;
          end
        FILTER0:
          if (!act) st_n = IDLE;
          else if (dcnt == DMAX) begin
            st_n    = DOWN;
            flag_n  = 1'b1;
            state_n = 1'b0;
            hcnt_n  = '0;
            rcnt_n  = '0;
            rep_n   = 1'b0;
          end else dcnt_n = dcnt + 1'b1;
        DOWN:
          if (!act) begin
            st_n   = FILTER1;
            dcnt_n = '0;
          end else if (!rep) begin
            if (hcnt == HMAX) begin
              lng_n  = 1'b1;
              rep_n  = 1'b1;
              rcnt_n = '0;
            end else hcnt_n = hcnt + 1'b1;
          end else if (REPEAT_EN != 0) begin
            rpt_n  = rcnt == RMAX;
            rcnt_n = rcnt == RMAX ? '0 : rcnt + 1'b1;
          end
        FILTER1:
          if (act) st_n = DOWN;
          else if (dcnt == DMAX) begin
            st_n    = IDLE;
            flag_n  = 1'b1;
            state_n = 1'b1;
            hcnt_n  = '0;
            rcnt_n  = '0;
            rep_n   = 1'b0;
          end else dcnt_n = dcnt + 1'b1;
        default: begin
          st_n    = IDLE;
          state_n = 1'b1;
          dcnt_n  = '0;
          hcnt_n  = '0;
          rcnt_n  = '0;
          rep_n   = 1'b0;
        end
      endcase
    end
    assign key_flag[i]  = flag;
    assign key_state[i] = state;
    assign key_long[i]  = lng;
    assign key_rpt[i]   = rpt;
  end
endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: scoreboard bench for key_filter_multi, repeat enabled and disabled instances side by side
module tb_key_filter_multi;
  logic Clk = 1'b0;
  logic Rst_n;
  logic [1:0] key_in;
  logic [1:0] flag_a, state_a, long_a, rpt_a;
  logic [1:0] flag_b, state_b, long_b, rpt_b;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [1:0] exp_state = 2'b11;
  typedef struct {
    int cyc;
    logic [1:0] flag;
    logic [1:0] lng;
    logic [1:0] rpt;
    logic [1:0] st;
  } ev_t;
  ev_t sb[$];
  key_filter_multi #(.KEY_NUM(2), .ACTIVE_LEVEL(0), .FILTER_CYC(8), .LONG_CYC(40),
                     .REPEAT_EN(1), .REPEAT_CYC(10)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .key_in(key_in),
    .key_flag(flag_a), .key_state(state_a), .key_long(long_a), .key_rpt(rpt_a));
  key_filter_multi #(.KEY_NUM(2), .ACTIVE_LEVEL(0), .FILTER_CYC(8), .LONG_CYC(40),
                     .REPEAT_EN(0), .REPEAT_CYC(10)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .key_in(key_in),
    .key_flag(flag_b), .key_state(state_b), .key_long(long_b), .key_rpt(rpt_b));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic push(input int c, input logic [1:0] f, input logic [1:0] l,
                      input logic [1:0] r, input logic [1:0] s);
    ev_t e;
    e.cyc = c;
    e.flag = f;
    e.lng = l;
    e.rpt = r;
    e.st = s;
    sb.push_back(e);
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  always @(negedge Clk) begin
    ev_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missed_event", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("flag_a", flag_a, e.flag);
      chk("long_a", long_a, e.lng);
      chk("rpt_a", rpt_a, e.rpt);
      chk("flag_b", flag_b, e.flag);
      chk("long_b", long_b, e.lng);
      chk("rpt_b", rpt_b, 0);
      exp_state = e.st;
    end else if (|{flag_a, long_a, rpt_a, flag_b, long_b, rpt_b})
      chk("spurious_pulse", {flag_a, long_a, rpt_a, flag_b, long_b, rpt_b}, 0);
    chk("state_a", state_a, exp_state);
    chk("state_b", state_b, exp_state);
  end
  initial begin
    int k, m, j, p, f, r, s, q;
    key_in = 2'b11;
    Rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_pulses", {flag_a, long_a, rpt_a}, 0);
    chk("reset_state", state_a, 2'b11);
    Rst_n = 1'b1;
    wait_cyc(3);
    k = cyc;
    key_in[0] = 1'b0;
    push(k + 11, 2'b01, 2'b00, 2'b00, 2'b10);
    wait_cyc(13);
    key_in[0] = 1'b1;
    wait_cyc(6);
    key_in[0] = 1'b0;
    wait_cyc(12);
    m = cyc;
    key_in[0] = 1'b1;
    push(m + 11, 2'b01, 2'b00, 2'b00, 2'b11);
    wait_cyc(15);
    key_in[0] = 1'b0;
    wait_cyc(5);
    key_in[0] = 1'b1;
    wait_cyc(2);
    j = cyc;
    key_in[0] = 1'b0;
    push(j + 11, 2'b01, 2'b00, 2'b00, 2'b10);
    wait_cyc(20);
    m = cyc;
    key_in[0] = 1'b1;
    push(m + 11, 2'b01, 2'b00, 2'b00, 2'b11);
    wait_cyc(15);
    p = cyc;
    f = p + 11;
    key_in[0] = 1'b0;
    push(f, 2'b01, 2'b00, 2'b00, 2'b10);
    push(f + 40, 2'b00, 2'b01, 2'b00, 2'b10);
    for (int i = 1; i <= 5; i++) push(f + 40 + 10 * i, 2'b00, 2'b00, 2'b01, 2'b10);
    wait_cyc(106);
    r = cyc;
    key_in[0] = 1'b1;
    push(r + 11, 2'b01, 2'b00, 2'b00, 2'b11);
    wait_cyc(20);
    s = cyc;
    key_in = 2'b00;
    push(s + 11, 2'b11, 2'b00, 2'b00, 2'b00);
    wait_cyc(31);
    Rst_n = 1'b0;
    exp_state = 2'b11;
    #1;
    chk("async_rst_state", state_a, 2'b11);
    chk("async_rst_pulses", {flag_a, long_a, rpt_a}, 0);
    wait_cyc(3);
    q = cyc;
    Rst_n = 1'b1;
    push(q + 11, 2'b11, 2'b00, 2'b00, 2'b00);
    wait_cyc(20);
    r = cyc;
    key_in = 2'b11;
    push(r + 11, 2'b11, 2'b00, 2'b00, 2'b11);
    wait_cyc(20);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
- Parametrised N-channel push-button debouncer with per-channel press/release flags and long-press and auto-repeat detection.
- Sits between raw board key pins and user logic, for example a menu, counter or LED controller.
- Each channel has an independent synchroniser, 4-state filter FSM, debounce counter and hold counter.
- All channels share one clock and one reset.

Parameters:
- KEY_NUM, 4: number of independent key channels (1..16).
- ACTIVE_LEVEL, 0: pin level meaning "pressed" (0 = active-low keys).
- FILTER_CYC, 1_000_000: consecutive stable clocks required to accept a level change (20 ms at 50 MHz).
- LONG_CYC, 50_000_000: clocks in DOWN before key_long fires (1 s at 50 MHz).
- REPEAT_EN, 1: 1 enables auto-repeat pulses after a long press; 0 disables them.
- REPEAT_CYC, 10_000_000: clocks between repeat pulses (200 ms at 50 MHz).

Ports:
- Clk, input, 1: system clock.
- Rst_n, input, 1: asynchronous active-low reset.
- key_in, input, KEY_NUM: raw asynchronous key pins.
- key_flag, output, KEY_NUM: 1-clock pulse when a debounced press or release is accepted.
- key_state, output, KEY_NUM: debounced level; 1 = released, 0 = pressed.
- key_long, output, KEY_NUM: 1-clock pulse when a press has been held LONG_CYC.
- key_rpt, output, KEY_NUM: 1-clock auto-repeat pulse while held past the long threshold.

Behaviour:
- Reset (async, Rst_n low):
  - All outputs are registered.
  - key_flag, key_long, key_rpt = 0; key_state = all 1s.
  - Synchroniser flops = ~ACTIVE_LEVEL, so no false edge after reset.
  - FSMs go to IDLE; all counters = 0.
- Synchroniser: 2 flops per channel. s = key_in delayed 2 clocks; act = (s == ACTIVE_LEVEL).
- FSM per channel (one-hot or binary):
  - IDLE: if act, go to FILTER0 with dcnt = 0.
  - FILTER0: if !act, go to IDLE (no flag). Else if dcnt == FILTER_CYC-1, go to DOWN, key_flag = 1, key_state = 0, hcnt = 0. Else dcnt++.
  - DOWN: if !act, go to FILTER1 with dcnt = 0. Else hcnt runs (see below).
  - FILTER1: if act, go back to DOWN (no flag; hcnt keeps its value, frozen while in FILTER1). Else if dcnt == FILTER_CYC-1, go to IDLE, key_flag = 1, key_state = 1. Else dcnt++.
- Latency: key_in stable from cycle k means key_flag is high in cycle k+FILTER_CYC+3, and key_state updates in the same cycle.
- Hold counter (DOWN only):
  - hcnt increments each clock in DOWN.
  - When hcnt == LONG_CYC-1: key_long pulses once per press, and the repeat phase starts with rcnt = 0.
  - In the repeat phase with REPEAT_EN = 1: rcnt increments. When rcnt == REPEAT_CYC-1, key_rpt pulses and rcnt = 0. The first key_rpt comes REPEAT_CYC clocks after key_long.
  - hcnt saturates after the long threshold; no wrap and no second key_long.
  - A release accepted in FILTER1 clears hcnt, rcnt and the repeat phase.
- Widths:
  - dcnt = $clog2(FILTER_CYC).
  - hcnt = $clog2(LONG_CYC).
  - rcnt = $clog2(REPEAT_CYC).
  - No overflow is possible by construction.
- Channel independence: simultaneous events on different channels each produce their own pulses in the same cycle, with no priority or interaction.
- Illegal FSM encoding: return to IDLE with key_state = 1 and all pulses 0.
- Reset mid-press: everything goes to reset values immediately. After release of reset with the key still held, a full FILTER_CYC filter is needed before a press flag.

Test Plan (KEY_NUM=2, FILTER_CYC=8, LONG_CYC=40, REPEAT_CYC=10, ACTIVE_LEVEL=0):
- Clean press: key_in[0] goes 1→0 at cycle k and stays low. Expect key_flag[0] = 1 only in cycle k+11, key_state[0] = 0 from k+11, and key_flag[1] = 0 throughout.
- Bounce rejection: key_in[0] low for 5 cycles, high for 2, then low and stable from cycle j. Expect no flag until j+11, then exactly one key_flag pulse.
- Release bounce: while pressed, a high glitch of 6 cycles. Expect no flag and key_state stays 0. Then a stable release at m gives key_flag at m+11 and key_state = 1.
- Long + repeat: hold key 0 for 100 cycles after the press flag. Expect key_long 40 cycles after entering DOWN, key_rpt every 10 cycles after that (5 pulses by hold 90), and no pulses after release is accepted.
- REPEAT_EN=0 variant, same stimulus: expect exactly one key_long and zero key_rpt.
- Simultaneous press plus async reset: both keys pressed in the same cycle, giving key_flag = 2'b11 in the same cycle. Assert Rst_n mid-hold. Expect immediate key_state = 2'b11 and pulses 0. After reset release with keys still low, expect new press flags 11 cycles later.
